seq_0110_framer_tx: RTL and testbench

Serial frame transmitter for the 0110 sync protocol. It takes a parallel payload word over a valid/ready handshake and emits a preamble of 0110, then the payload MSB-first on a single-bit line. It inserts stuffed '1' bits so the non-overlapping Mealy 0110 sync detector at the far end never sees a false sync inside the payload. Between frames it drives an idle-high line with a mandatory guard gap.

---
 rtl/seq_0110_framer_tx_if.sv | 23 ++
 rtl/seq_0110_framer_tx.sv | 145 ++++++++++++++
 tb/tb_seq_0110_framer_tx.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_0110_framer_tx_if.sv
// Payload handshake and serial-line bundle for the 0110 sync framer.
// The master side offers payload words; the slave side is the framer.
interface seq_0110_framer_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx_bit;
    logic              tx_active;
    logic              stuff_bit;
    logic              done;

    modport master (
        output in_valid, in_data,
        input  in_ready, tx_bit, tx_active, stuff_bit, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, tx_bit, tx_active, stuff_bit, done
    );
endinterface

// File: rtl/seq_0110_framer_tx.sv
// Serial frame transmitter: 0110 preamble, MSB-first payload with '1' stuffing
// after every 011 so a far-end 0110 detector never syncs inside the payload.
module seq_0110_framer_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAP    = 2
) (
    input  logic                clk,
    input  logic                reset,
    seq_0110_framer_tx_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned PH_MAX = (GAP > 4) ? GAP : 4;
    localparam int unsigned PH_W   = $clog2(PH_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_STUFF,
        S_GAP
    } state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] sreg, sreg_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [2:0]        hist, hist_nx, hist_upd;
    logic [PH_W-1:0]   ph, ph_nx;

    logic tx_bit_q, tx_bit_nx;
    logic tx_active_q, tx_active_nx;
    logic stuff_q, stuff_nx;
    logic done_q, done_nx;

    // State, datapath and registered line outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            sreg        <= '0;
            cnt         <= '0;
            hist        <= 3'b111;
            ph          <= '0;
            tx_bit_q    <= 1'b1;
            tx_active_q <= 1'b0;
            stuff_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            sreg        <= sreg_nx;
            cnt         <= cnt_nx;
            hist        <= hist_nx;
            ph          <= ph_nx;
            tx_bit_q    <= tx_bit_nx;
            tx_active_q <= tx_active_nx;
            stuff_q     <= stuff_nx;
            done_q      <= done_nx;
        end
    end

    // Next state plus the line values that the next state will present
    always_comb begin
        state_nx     = state;
        sreg_nx      = sreg;
        cnt_nx       = cnt;
        hist_nx      = hist;
        hist_upd     = {hist[1:0], sreg[DATA_W-1]};
        ph_nx        = ph;
        tx_bit_nx    = 1'b1;
        tx_active_nx = 1'b0;
        stuff_nx     = 1'b0;
        done_nx      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sreg_nx  = bus.in_data;
                    ph_nx    = '0;
                    state_nx = S_PRE;
                end
            end
            S_PRE: begin
                if (ph == PH_W'(3)) begin
                    cnt_nx   = CNT_W'(DATA_W);
                    hist_nx  = 3'b111;
                    state_nx = S_DATA;
                end else begin
                    ph_nx = ph + PH_W'(1);
                end
            end
            S_DATA: begin
                sreg_nx = sreg << 1;
                cnt_nx  = cnt - CNT_W'(1);
                hist_nx = hist_upd;
                if (hist_upd == 3'b011) begin
                    state_nx = S_STUFF;
                end else if (cnt_nx == '0) begin
                    ph_nx    = '0;
                    state_nx = S_GAP;
                end
            end
            S_STUFF: begin
                hist_nx = 3'b111;
                if (cnt != '0) begin
                    state_nx = S_DATA;
                end else begin
                    ph_nx    = '0;
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (ph == PH_W'(GAP - 1)) begin
                    state_nx = S_IDLE;
                end else begin
                    ph_nx = ph + PH_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase

        unique case (state_nx)
            S_PRE: begin
                // Preamble index 0..3 maps to 0,1,1,0
                tx_bit_nx    = ph_nx[0] ^ ph_nx[1];
                tx_active_nx = 1'b1;
            end
            S_DATA: begin
                tx_bit_nx    = sreg_nx[DATA_W-1];
                tx_active_nx = 1'b1;
            end
            S_STUFF: begin
                tx_active_nx = 1'b1;
                stuff_nx     = 1'b1;
            end
            S_GAP: begin
                done_nx = (state != S_GAP);
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.tx_bit    = tx_bit_q;
    assign bus.tx_active = tx_active_q;
    assign bus.stuff_bit = stuff_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_0110_framer_tx.sv
// Randomised bench for seq_0110_framer_tx: two instances (GAP=2, GAP=4) each
// shadowed by a frame-level reference model and a far-end 0110 detector.
module tb_seq_0110_framer_tx;
    localparam int unsigned DW = 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          vld0 = 1'b0, vld1 = 1'b0;
    logic [DW-1:0] dat0 = '0, dat1 = '0;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int unsigned GP = (g == 0) ? 2 : 4;

        seq_0110_framer_tx_if #(.DATA_W(DW)) bus ();
        seq_0110_framer_tx #(.DATA_W(DW), .GAP(GP)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );
        assign bus.in_valid = (g == 0) ? vld0 : vld1;
        assign bus.in_data  = (g == 0) ? dat0 : dat1;

        // Reference: expected line bits of the current frame, built from the payload
        bit            exp_bits[$];
        bit            exp_stf[$];
        int            mode = 0;      // 0 idle, 1 frame, 2 gap
        int            pos = 0, gap_left = 0, win_n = 0;
        bit            first_gap = 1'b0, prev_act = 1'b0;
        logic [3:0]    win = '0;
        logic [DW-1:0] cur_word = '0, got_word = '0;
        logic [13:0]   shape = '0;
        int            syncs = 0, frames = 0, dlen = 0, dstf = 0, ndone = 0;
        int            done_cyc = 0, gap_meas = 0;

        always @(negedge clk) begin
            logic       e_bit, e_stf, e_act, e_done;
            logic [2:0] t;
            logic [3:0] pre;
            pre = 4'b0110;
            if (reset) begin
                check("rst_tx_bit", bus.tx_bit, 1);
                check("rst_tx_active", bus.tx_active, 0);
                check("rst_stuff_bit", bus.stuff_bit, 0);
                check("rst_done", bus.done, 0);
                check("rst_in_ready", bus.in_ready, 1);
                mode = 0;
                exp_bits.delete();
                exp_stf.delete();
                win_n    = 0;
                prev_act = 1'b0;
            end else begin
                e_bit = 1'b1; e_stf = 1'b0; e_act = 1'b0; e_done = 1'b0;
                if (mode == 1) begin
                    e_bit = exp_bits[0];
                    e_stf = exp_stf[0];
                    e_act = 1'b1;
                end else if (mode == 2) begin
                    e_done = first_gap;
                end
                check("tx_bit", bus.tx_bit, e_bit);
                check("tx_active", bus.tx_active, e_act);
                check("stuff_bit", bus.stuff_bit, e_stf);
                check("done", bus.done, e_done);
                check("in_ready", bus.in_ready, mode == 0);

                // Observations taken purely from the line
                if (bus.tx_active && !prev_act) begin
                    dlen = 0; dstf = 0; ndone = 0; shape = '0;
                    gap_meas = cyc - done_cyc;
                end
                if (bus.tx_active) begin
                    if (!bus.stuff_bit && dlen >= 4) got_word = {got_word[DW-2:0], bus.tx_bit};
                    dlen++;
                    dstf += int'(bus.stuff_bit);
                    shape = {shape[12:0], bus.tx_bit};
                end
                if (bus.done) begin
                    ndone++;
                    done_cyc = cyc;
                end
                prev_act = bus.tx_active;

                // Far-end non-overlapping 0110 detector
                win = {win[2:0], bus.tx_bit};
                win_n++;
                if (win_n >= 4 && win == 4'b0110) begin
                    syncs++;
                    win_n = 0;
                    check("sync_at_preamble_end", (mode == 1 && pos == 3), 1);
                end

                case (mode)
                    0: if (bus.in_valid) begin
                        cur_word = bus.in_data;
                        frames++;
                        pos  = 0;
                        mode = 1;
                        for (int i = 3; i >= 0; i--) begin
                            exp_bits.push_back(pre[i]);
                            exp_stf.push_back(1'b0);
                        end
                        // A '1' goes out after any 011 formed since the preamble or last stuff
                        t = 3'b111;
                        for (int i = DW - 1; i >= 0; i--) begin
                            exp_bits.push_back(cur_word[i]);
                            exp_stf.push_back(1'b0);
                            t = {t[1:0], cur_word[i]};
                            if (t == 3'b011) begin
                                exp_bits.push_back(1'b1);
                                exp_stf.push_back(1'b1);
                                t = 3'b111;
                            end
                        end
                    end
                    1: begin
                        void'(exp_bits.pop_front());
                        void'(exp_stf.pop_front());
                        pos++;
                        if (exp_bits.size() == 0) begin
                            check("destuffed_payload", got_word, cur_word);
                            mode      = 2;
                            gap_left  = GP;
                            first_gap = 1'b1;
                        end
                    end
                    default: begin
                        first_gap = 1'b0;
                        gap_left--;
                        if (gap_left == 0) mode = 0;
                    end
                endcase
            end
        end
    end

    task automatic drive(input int g, input logic v, input logic [DW-1:0] d);
        if (g == 0) begin vld0 = v; dat0 = d; end
        else        begin vld1 = v; dat1 = d; end
    endtask

    function automatic logic rdy(input int g);
        return (g == 0) ? u[0].bus.in_ready : u[1].bus.in_ready;
    endfunction

    function automatic int mode_of(input int g);
        return (g == 0) ? u[0].mode : u[1].mode;
    endfunction

    // Offer a word and return just after the accepting edge
    task automatic send(input int g, input logic [DW-1:0] w, input bit keep);
        int t;
        t = 0;
        drive(g, 1'b1, w);
        do begin
            @(negedge clk);
            t++;
        end while (!rdy(g) && t < 200);
        check("handshake_within_bound", t < 200, 1);
        @(posedge clk);
        #1;
        if (!keep) drive(g, 1'b0, '0);
    endtask

    task automatic wait_idle(input int g);
        int t;
        t = 0;
        @(negedge clk);
        #1;
        while (mode_of(g) != 0 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("frame_ends_within_bound", t < 200, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 200000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit keep;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        send(0, 8'h66, 1'b0);
        wait_idle(0);
        check("f66_shape", u[0].shape, 14'b01100111001110);
        check("f66_len", u[0].dlen, 14);
        check("f66_stuffs", u[0].dstf, 2);
        check("f66_done_pulses", u[0].ndone, 1);

        send(0, 8'hFF, 1'b0);
        wait_idle(0);
        check("fff_len", u[0].dlen, 12);
        check("fff_stuffs", u[0].dstf, 0);

        send(0, 8'h00, 1'b0);
        wait_idle(0);
        check("f00_len", u[0].dlen, 12);
        check("f00_stuffs", u[0].dstf, 0);

        send(0, 8'h33, 1'b0);
        wait_idle(0);
        check("f33_shape", u[0].shape, 14'b01100011100111);
        check("f33_len", u[0].dlen, 14);
        check("f33_stuffs", u[0].dstf, 2);

        s0 = u[0].syncs;
        send(0, 8'h5A, 1'b1);
        send(0, 8'hC3, 1'b0);
        wait_idle(0);
        check("b2b_done_to_preamble", u[0].gap_meas, 3);
        check("b2b_sync_count", u[0].syncs - s0, 2);

        // Reset during the third payload bit (a 0) of an all-zero word
        send(0, 8'h00, 1'b0);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_tx_bit", u[0].bus.tx_bit, 1);
        check("rst_mid_tx_active", u[0].bus.tx_active, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_mid_no_done", u[0].ndone, 0);

        send(0, 8'h66, 1'b0);
        wait_idle(0);
        check("after_rst_shape", u[0].shape, 14'b01100111001110);
        check("after_rst_done_pulses", u[0].ndone, 1);

        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 500; k++) begin
                keep = 1'($urandom_range(0, 1));
                send(g, DW'($urandom), keep);
                if (!keep) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    #1;
                end
            end
            drive(g, 1'b0, '0);
            wait_idle(g);
        end

        check("soak_frames_gap4", u[1].frames, 500);
        check("syncs_eq_frames_gap2", u[0].syncs, u[0].frames);
        check("syncs_eq_frames_gap4", u[1].syncs, u[1].frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
